// File: rtl/sfq_and2_capture.sv
// -----------------------------------------------------------------------------
// sfq_and2_capture
//
// Purpose:
//   This is the capture stage behind the clocked two-input SFQ AND gate. Both
//   SFQ lines are toggle-encoded, so every edge on a line is one pulse.
//   Each SFQ clock window yields one bit: the bit is 1 if a gate output pulse
//   arrived in that window, otherwise 0. The bits are packed into WIDTH-bit
//   words on the conventional clk domain.
//
// Parameters:
//   WIDTH       - bits per output word (2..32)
//   SYNC_STAGES - synchroniser flops per SFQ line (2..4)
//
// Ports:
//   clk         in   sampling clock, at least 4x the SFQ pulse rate
//   rst         in   asynchronous active-high reset
//   sfq_clk_in  in   SFQ clock line (any edge = one clock pulse)
//   sfq_data_in in   gate q line (any edge = one data pulse)
//   out_word    out  assembled word, bit 0 = earliest window
//   out_valid   out  out_word holds an unread word
//   out_ready   in   consumer ready
//   err_clr     in   one-cycle pulse that clears the sticky error flags
//   overflow    out  sticky: a completed word was dropped
//   dbl_pulse   out  sticky: two data pulses arrived in one window
// -----------------------------------------------------------------------------
module sfq_and2_capture #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sfq_clk_in,
  input  logic             sfq_data_in,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic             overflow,
  output logic             dbl_pulse
);

  localparam int                CNT_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [2:0]        SETTLE_INIT = 3'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // Synchronisers, edge reference flops and settle counter
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_ref;
  logic                   r_dat_ref;
  logic [2:0]             r_settle;

  // The reference flops track the synchronised level at all times. During
  // settle the XOR is masked, so a line that rests at 1 coming out of reset
  // is absorbed into the reference and is not seen as a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync <= '0;
      r_dat_sync <= '0;
      r_clk_ref  <= 1'b0;
      r_dat_ref  <= 1'b0;
      r_settle   <= SETTLE_INIT;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], sfq_clk_in};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], sfq_data_in};
      r_clk_ref  <= r_clk_sync[SYNC_STAGES-1];
      r_dat_ref  <= r_dat_sync[SYNC_STAGES-1];
      if (r_settle != 3'd0) begin
        r_settle <= r_settle - 3'd1;
      end
    end
  end

  logic w_settled;
  logic w_clk_pulse;
  logic w_dat_pulse;

  assign w_settled   = (r_settle == 3'd0);
  assign w_clk_pulse = (r_clk_sync[SYNC_STAGES-1] ^ r_clk_ref) & w_settled;
  assign w_dat_pulse = (r_dat_sync[SYNC_STAGES-1] ^ r_dat_ref) & w_settled;

  // ---------------------------------------------------------------------------
  // Window / bit assembly
  //
  // The next-state logic is written as gate expressions and ternaries rather
  // than if-statements. An X on a pulse then reaches the state registers
  // and is not silently treated as "no pulse".
  // ---------------------------------------------------------------------------
  logic             r_armed;
  logic             r_pending;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_shift;

  logic             w_commit;
  logic             w_bit;
  logic             w_done;
  logic             w_dbl_ev;
  logic             w_pending_n;
  logic [CNT_W-1:0] w_bit_cnt_n;
  logic [WIDTH-1:0] w_bit_sel;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] w_shift_n;

  // The first clock pulse after reset only opens a window. Every later clock
  // pulse closes the current window and commits one bit.
  assign w_commit = w_clk_pulse & r_armed;

  // A data pulse that coincides with a clock pulse belongs to the window
  // being closed. It is therefore ORed into the committed bit and does not
  // carry over into the next window.
  assign w_bit    = r_pending | w_dat_pulse;
  assign w_dbl_ev = w_dat_pulse & r_pending & r_armed;
  assign w_done   = w_commit & (r_bit_cnt == LAST_BIT);

  assign w_pending_n = w_clk_pulse ? 1'b0 : (r_pending | (w_dat_pulse & r_armed));
  assign w_bit_cnt_n = w_commit ? (w_done ? '0 : r_bit_cnt + CNT_W'(1)) : r_bit_cnt;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bits
    assign w_bit_sel[gi] = w_commit & (r_bit_cnt == CNT_W'(gi));
    assign w_word[gi]    = w_bit_sel[gi] ? w_bit : r_shift[gi];
  end

  // Once a word is complete its bits have been handed on (or dropped), so
  // the shift register restarts clean.
  assign w_shift_n = w_done ? '0 : w_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed   <= 1'b0;
      r_pending <= 1'b0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_armed   <= r_armed | w_clk_pulse;
      r_pending <= w_pending_n;
      r_bit_cnt <= w_bit_cnt_n;
      r_shift   <= w_shift_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register and handshake
  //
  // Valid/ready: a word transfers on any clk rise where out_valid and
  // out_ready are both high. out_valid never drops and out_word never changes
  // until that transfer happens. A completed word may load in the same cycle
  // as a transfer (back-to-back). A word that completes while an unread word
  // is still held is dropped and flagged as overflow.
  // ---------------------------------------------------------------------------
  logic w_load;
  logic w_ovf_ev;

  assign w_load   = w_done & (~out_valid | out_ready);
  assign w_ovf_ev = w_done & out_valid & ~out_ready;

  // A new error event takes priority over err_clr in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_word  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      dbl_pulse <= 1'b0;
    end else begin
      out_word  <= w_load ? w_word : out_word;
      out_valid <= w_load | (out_valid & ~out_ready);
      overflow  <= w_ovf_ev | (overflow & ~err_clr);
      dbl_pulse <= w_dbl_ev | (dbl_pulse & ~err_clr);
    end
  end

endmodule

// File: tb/tb_sfq_and2_capture.sv
// -----------------------------------------------------------------------------
// tb_sfq_and2_capture
//
// Directed bench for sfq_and2_capture (WIDTH=8, SYNC_STAGES=2). SFQ lines are
// toggled one clk after a rising edge. A negedge monitor pops expected words
// from exp_q whenever out_valid and out_ready are both high.
// -----------------------------------------------------------------------------
module tb_sfq_and2_capture;

  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         sfq_clk_in;
  logic         sfq_data_in;
  logic [W-1:0] out_word;
  logic         out_valid;
  logic         out_ready;
  logic         err_clr;
  logic         overflow;
  logic         dbl_pulse;

  sfq_and2_capture #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .sfq_clk_in  (sfq_clk_in),
    .sfq_data_in (sfq_data_in),
    .out_word    (out_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err_clr     (err_clr),
    .overflow    (overflow),
    .dbl_pulse   (dbl_pulse)
  );

  int checks      = 0;
  int failures    = 0;
  int valid_cycles = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SFQ clock pulse opens a window lasting 50 clk cycles. d1/d2 place
  // data pulses 10 and 20 cycles into that window.
  task automatic window(input bit d1, input bit d2);
    sfq_clk_in = ~sfq_clk_in;
    gap(10);
    if (d1) sfq_data_in = ~sfq_data_in;
    gap(10);
    if (d2) sfq_data_in = ~sfq_data_in;
    gap(30);
  endtask

  // scoreboard monitor: a word is transferred at the next rise
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1) valid_cycles++;
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      chk("word_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("out_word", 32'(out_word), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    logic [8:0] t1_data;
    rst         = 1'b1;
    sfq_clk_in  = 1'b0;
    sfq_data_in = 1'b0;
    out_ready   = 1'b0;
    err_clr     = 1'b0;
    gap(3);
    chk("rst_out_word", 32'(out_word), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_dbl_pulse", 32'(dbl_pulse), 32'd0);
    rst = 1'b0;
    gap(10);

    // Step 1: arming pulse + 8 windows. Data arrives in windows 0, 2 and 7,
    // so the word is 8'b1000_0101. The last pulse opens an empty window.
    t1_data = 9'b0_1000_0101;
    exp_q.push_back(8'h85);
    for (int i = 0; i < 9; i++) window(t1_data[i], 1'b0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_word", 32'(out_word), 32'h85);
    chk("t1_overflow", 32'(overflow), 32'd0);
    chk("t1_dbl", 32'(dbl_pulse), 32'd0);

    // Step 2: consumer stalled for 16 empty windows; both new words are dropped.
    for (int i = 0; i < 8; i++) window(1'b0, 1'b0);
    chk("t2_overflow_first_drop", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) window(1'b0, 1'b0);
    chk("t2_word_held", 32'(out_word), 32'h85);
    chk("t2_valid_held", 32'(out_valid), 32'd1);
    chk("t2_overflow", 32'(overflow), 32'd1);
    err_clr = 1'b1;
    gap(1);
    err_clr = 1'b0;
    gap(1);
    chk("t2_overflow_cleared", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    gap(3);
    chk("t2_valid_after_read", 32'(out_valid), 32'd0);

    // Step 3: two data pulses in the open window -> bit0=1 with dbl_pulse.
    // Then a clock and data pulse in the same cycle -> bit1=1, bit2=0.
    exp_q.push_back(8'h03);
    sfq_data_in = ~sfq_data_in;
    gap(10);
    sfq_data_in = ~sfq_data_in;
    gap(20);
    window(1'b0, 1'b0);
    chk("t3_dbl_pulse", 32'(dbl_pulse), 32'd1);
    sfq_clk_in  = ~sfq_clk_in;
    sfq_data_in = ~sfq_data_in;
    gap(50);
    chk("t3_dbl_still_set", 32'(dbl_pulse), 32'd1);
    for (int i = 0; i < 6; i++) window(1'b0, 1'b0);
    chk("t3_valid_after_read", 32'(out_valid), 32'd0);
    err_clr = 1'b1;
    gap(1);
    err_clr = 1'b0;
    gap(1);
    chk("t3_dbl_cleared", 32'(dbl_pulse), 32'd0);

    // Step 4: both lines rest at 1 through reset; no pulse may be seen.
    rst         = 1'b1;
    sfq_clk_in  = 1'b1;
    sfq_data_in = 1'b1;
    gap(3);
    rst = 1'b0;
    gap(20);
    chk("t4_armed", 32'(dut.r_armed), 32'd0);
    chk("t4_bit_cnt", 32'(dut.r_bit_cnt), 32'd0);
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_dbl", 32'(dbl_pulse), 32'd0);

    // Step 5: arm + 5 committed bits, reset, then a clean all-ones word.
    for (int i = 0; i < 6; i++) window(1'b1, 1'b0);
    chk("t5_partial_cnt", 32'(dut.r_bit_cnt), 32'd5);
    rst = 1'b1;
    gap(2);
    rst = 1'b0;
    gap(10);
    chk("t5_cnt_after_rst", 32'(dut.r_bit_cnt), 32'd0);
    chk("t5_valid_after_rst", 32'(out_valid), 32'd0);
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 8; i++) window(1'b1, 1'b0);
    window(1'b0, 1'b0);
    chk("t5_valid_after_read", 32'(out_valid), 32'd0);

    // Step 6: ready held high, 16 empty windows -> two 8'h00 words, each
    // valid for exactly one cycle.
    valid_cycles = 0;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    for (int i = 0; i < 16; i++) window(1'b0, 1'b0);
    chk("t6_valid_cycles", 32'(valid_cycles), 32'd2);
    chk("t6_overflow", 32'(overflow), 32'd0);

    // drain: every expected word must have been observed
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) gap(1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
